// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder bank, the frame accumulator and the result consumer.
// The slave side is the accumulator; the master side is the environment around it.
interface sum_accumulator_if #(
  parameter int N     = 16,
  parameter int ACC_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_sum;
  logic             in_cout;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  modport slave (
    input  in_valid, in_sum, in_cout, out_ready,
    output in_ready, out_valid, out_acc, out_ovf
  );

  modport master (
    output in_valid, in_sum, in_cout, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates CNT adder results {cout, sum} into one frame total with a sticky overflow flag.
// Optional macro ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module sum_accumulator #(
  parameter int N     = 16,
  parameter int ACC_W = 24,
  parameter int CNT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sum_accumulator_if.slave     bus,
  output logic                 busy
);
  localparam int CNT_W = $clog2(CNT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             ready_en_reg;

  logic [ACC_W-1:0] v_ext;
  logic [ACC_W:0]   sum_wide;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;

  assign v_ext    = ACC_W'({bus.in_cout, bus.in_sum});
  assign sum_wide = {1'b0, acc_reg} + {1'b0, v_ext};
  assign cnt_inc  = cnt_reg + CNT_W'(1);

  // ready_en_reg keeps in_ready low until the first edge after reset releases
  assign bus.in_ready  = ready_en_reg & (state_reg != HOLD);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state_reg == HOLD);
  assign bus.out_acc   = acc_reg;
  assign bus.out_ovf   = ovf_reg;
  assign busy          = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      ovf_reg      <= 1'b0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      ovf_reg      <= ovf_next;
      ready_en_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          acc_next   = v_ext;
          cnt_next   = CNT_W'(1);
          ovf_next   = 1'b0;
          state_next = (CNT == 1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          cnt_next = cnt_inc;
          ovf_next = ovf_reg | sum_wide[ACC_W];
`ifdef ACC_SAT_EN
          // once saturated, the total stays pinned at all-ones for the frame
          if (ovf_reg || sum_wide[ACC_W]) begin
            acc_next = '1;
          end else begin
            acc_next = sum_wide[ACC_W-1:0];
          end
`else
          acc_next = sum_wide[ACC_W-1:0];
`endif
          if (cnt_inc == CNT_LAST) begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        // acc is left untouched so out_acc still shows the last total
        if (bus.out_ready) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator: default instance plus a narrow ACC_W=17, CNT=2 instance for overflow.
module tb_sum_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy1, busy2;
  int   checks = 0;
  int   errors = 0;

  sum_accumulator_if #(.N(16), .ACC_W(24)) bus ();
  sum_accumulator_if #(.N(16), .ACC_W(17)) bus2 ();

  sum_accumulator #(.N(16), .ACC_W(24), .CNT(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy1)
  );
  sum_accumulator #(.N(16), .ACC_W(17), .CNT(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one accepted beat on the default instance, bounded wait for in_ready
  task automatic accept(input logic [15:0] s, input logic c);
    int w = 0;
    bus.in_valid = 1'b1;
    bus.in_sum   = s;
    bus.in_cout  = c;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", bus.in_ready);
    end else begin
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic release_frame();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.out_acc !== 24'h0) begin errors++; $display("FAIL reset_out_acc: got %h required 000000", bus.out_acc); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b required 0", bus.out_ovf); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy1); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
    $display("reset: out_valid=%b out_acc=%h busy=%b in_ready=%b", bus.out_valid, bus.out_acc, busy1, bus.in_ready);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 8; i++) begin
      accept(16'h0001, 1'b0);
      if (i == 6) begin
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b required 0", bus.out_valid); end
      end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.out_acc !== 24'h000008) begin errors++; $display("FAIL basic_out_acc: got %h required 000008", bus.out_acc); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL basic_out_ovf: got %b required 0", bus.out_ovf); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b required 1", busy1); end
    $display("basic frame: out_acc=%h out_ovf=%b", bus.out_acc, bus.out_ovf);
    release_frame();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_release: out_valid=%b required 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) accept(16'hFFFF, 1'b1);
    checks++; if (bus.out_acc !== 24'h0FFFF8) begin errors++; $display("FAIL b2b_out_acc: got %h required 0ffff8", bus.out_acc); end
    checks++; if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL b2b_out_ovf: got %b required 0", bus.out_ovf); end
    $display("back-to-back frame: out_acc=%h out_ovf=%b", bus.out_acc, bus.out_ovf);
    release_frame();
  endtask

  task automatic test_overflow();
    logic [16:0] exp_acc;
`ifdef ACC_SAT_EN
    exp_acc = 17'h1FFFF;
`else
    exp_acc = 17'h1FFFE;
`endif
    checks++; if (bus2.in_ready !== 1'b1) begin errors++; $display("FAIL ovf_in_ready: got %b required 1", bus2.in_ready); end
    bus2.in_valid = 1'b1;
    bus2.in_sum   = 16'hFFFF;
    bus2.in_cout  = 1'b1;
    tick();
    tick();
    bus2.in_valid = 1'b0;
    checks++; if (bus2.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_out_valid: got %b required 1", bus2.out_valid); end
    checks++; if (bus2.out_acc !== exp_acc) begin errors++; $display("FAIL ovf_out_acc: got %h required %h", bus2.out_acc, exp_acc); end
    checks++; if (bus2.out_ovf !== 1'b1) begin errors++; $display("FAIL ovf_out_ovf: got %b required 1", bus2.out_ovf); end
    $display("overflow frame: out_acc=%h out_ovf=%b", bus2.out_acc, bus2.out_ovf);
    bus2.out_ready = 1'b1;
    tick();
    bus2.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) accept(16'h0001, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_sum   = 16'h0100;
    bus.in_cout  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: cycle %0d got %b required 0", i, bus.in_ready); end
      checks++; if (bus.out_acc !== 24'h000008) begin errors++; $display("FAIL bp_out_acc: cycle %0d got %h required 000008", i, bus.out_acc); end
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    checks++; if (bus.out_acc !== 24'h000008) begin errors++; $display("FAIL bp_handshake_no_accept: got %h required 000008", bus.out_acc); end
    accept(16'h0005, 1'b0);
    checks++; if (bus.out_acc !== 24'h000005) begin errors++; $display("FAIL bp_fresh_frame: got %h required 000005", bus.out_acc); end
    for (int i = 0; i < 7; i++) accept(16'h0005, 1'b0);
    checks++; if (bus.out_acc !== 24'h000028) begin errors++; $display("FAIL bp_total: got %h required 000028", bus.out_acc); end
    $display("backpressure frame: out_acc=%h", bus.out_acc);
    release_frame();
  endtask

  task automatic test_toggle();
    int accepted = 0;
    int cyc = 0;
    while (accepted < 8 && cyc < 40) begin
      bus.in_valid = (cyc % 2 == 0);
      bus.in_sum   = 16'(accepted + 1);
      bus.in_cout  = 1'b0;
      if (bus.in_valid && bus.in_ready) accepted++;
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    checks++; if (accepted != 8) begin errors++; $display("FAIL toggle_timeout: accepted %0d required 8", accepted); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL toggle_out_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.out_acc !== 24'h000024) begin errors++; $display("FAIL toggle_out_acc: got %h required 000024", bus.out_acc); end
    $display("toggle frame: out_acc=%h after %0d cycles", bus.out_acc, cyc);
    release_frame();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) accept(16'h0100, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus.out_acc !== 24'h0) begin errors++; $display("FAIL arst_out_acc: got %h required 000000", bus.out_acc); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL arst_busy: got %b required 0", busy1); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_ovf !== 1'b0) begin errors++; $display("FAIL arst_flags: valid=%b ovf=%b required 0 0", bus.out_valid, bus.out_ovf); end
    #2;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) accept(16'h0002, 1'b0);
    checks++; if (bus.out_acc !== 24'h000010) begin errors++; $display("FAIL arst_total: got %h required 000010", bus.out_acc); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL arst_out_valid: got %b required 1", bus.out_valid); end
    $display("post-reset frame: out_acc=%h", bus.out_acc);
    release_frame();
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_sum     = '0;
    bus.in_cout    = 1'b0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_sum    = '0;
    bus2.in_cout   = 1'b0;
    bus2.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_toggle();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
